// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM.
// It accepts one access at a time, checks its alignment, issues it to the RAM
// for one cycle, and returns a done pulse to the winning requester.
// Outputs are all registered. Fetch data is captured one cycle after issue.

package ram_pkg;
  localparam int QUAD_W = 64;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    WORD = 2'd1,
    LONG = 2'd2,
    QUAD = 2'd3
  } ram_size_t;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;
endpackage

module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDRW = 17,
  parameter int DATAW = QUAD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  ram_size_t         size0,
  input  ram_size_t         size1,
  input  logic [ADDRW-1:0]  addr0,
  input  logic [ADDRW-1:0]  addr1,
  input  logic [DATAW-1:0]  wdata0,
  input  logic [DATAW-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATAW-1:0]  rdata,
  output logic              busy,
  output ram_op_t           ram_op,
  output ram_size_t         ram_size,
  output logic [ADDRW-1:0]  ram_addr,
  output logic [DATAW-1:0]  ram_data_in,
  input  logic [DATAW-1:0]  ram_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Port that won the most recent arbitration; starts at 1 so port 0 wins the first tie.
  logic last_grant;
  // Port owning the access in flight, and whether that access is a store.
  logic owner;
  logic we_q;

  // Arbitration result for the current IDLE cycle.
  logic             any_req;
  logic             win;
  logic             sel_we;
  ram_size_t        sel_size;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_wdata;
  logic             sel_aligned;

  // Natural alignment: the low address bits below the access size must be zero.
  function automatic logic is_aligned(input ram_size_t sz, input logic [2:0] lsb);
    case (sz)
      BYTE:    is_aligned = 1'b1;
      WORD:    is_aligned = (lsb[0] == 1'b0);
      LONG:    is_aligned = (lsb[1:0] == 2'b00);
      default: is_aligned = (lsb == 3'b000);
    endcase
  endfunction

  // Round-robin pick: a lone requester always wins, on a tie the port not granted last wins.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      pick_winner = ~last;
    end else begin
      pick_winner = r1;
    end
  endfunction

  // Select the winner and its payload from the live request inputs.
  always_comb begin
    any_req     = req0 | req1;
    win         = pick_winner(req0, req1, last_grant);
    sel_we      = win ? we1    : we0;
    sel_size    = win ? size1  : size0;
    sel_addr    = win ? addr1  : addr0;
    sel_wdata   = win ? wdata1 : wdata0;
    sel_aligned = is_aligned(sel_size, sel_addr[2:0]);
  end

  // Latch the winner's payload at acceptance so later requester changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && any_req) begin
      ram_addr    <= sel_addr;
      ram_size    <= sel_size;
      ram_data_in <= sel_wdata;
    end
  end

  // Access sequencer with registered handshake, RAM command and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ram_op     <= RAM_NOP;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= win;
            owner      <= win;
            we_q       <= sel_we;
            gnt0       <= ~win;
            gnt1       <= win;
            busy       <= 1'b1;
            if (sel_aligned) begin
              state  <= ISSUE;
              ram_op <= sel_we ? RAM_STORE : RAM_FETCH;
              err    <= 1'b0;
            end else begin
              // Misaligned: never touches the RAM, completes straight away with err.
              state  <= DONE;
              ram_op <= RAM_NOP;
              err    <= 1'b1;
              rdata  <= '0;
              done0  <= ~win;
              done1  <= win;
            end
          end else begin
            ram_op <= RAM_NOP;
            err    <= 1'b0;
            busy   <= 1'b0;
          end
        end
        ISSUE: begin
          // The command was visible to the RAM for exactly this one cycle.
          state  <= WAIT;
          ram_op <= RAM_NOP;
        end
        WAIT: begin
          // RAM read data arrives one cycle after the fetch command.
          state <= DONE;
          if (!we_q) begin
            rdata <= ram_data_out;
          end
          done0 <= ~owner;
          done1 <= owner;
          err   <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ram_op <= RAM_NOP;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level model with a byte-array RAM.

module tb_ram_arbiter;
  import ram_pkg::*;

  localparam int ADDRW = 17;
  localparam int DATAW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, we0, we1;
  ram_size_t        size0, size1;
  logic [ADDRW-1:0] addr0, addr1;
  logic [DATAW-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, done0, done1, err, busy;
  logic [DATAW-1:0] rdata;
  ram_op_t          ram_op;
  ram_size_t        ram_size;
  logic [ADDRW-1:0] ram_addr;
  logic [DATAW-1:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .rdata(rdata), .busy(busy),
    .ram_op(ram_op), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Reference model state: one transaction record plus scheduling arithmetic.
  int              cyc = 0;
  bit              act, t_al, t_we, t_own, last;
  int              tg, idle_at;
  ram_size_t       t_sz;
  logic [ADDRW-1:0] t_addr;
  logic [63:0]     t_wd, t_rd, exp_rdata;
  logic [7:0]      ref_mem [256];
  logic [7:0]      env_mem [256];
  logic [63:0]     env_pend;
  bit              env_pend_v;
  bit              g0, g1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int nbytes(input ram_size_t s);
    return 1 << int'(s);
  endfunction

  function automatic bit tb_aligned(input ram_size_t s, input logic [ADDRW-1:0] a);
    return (int'(a) % nbytes(s)) == 0;
  endfunction

  function automatic logic [63:0] mem_rd(input bit env, input logic [ADDRW-1:0] a, input ram_size_t s);
    logic [63:0] v = '0;
    for (int k = 0; k < nbytes(s); k++)
      v[8*k +: 8] = env ? env_mem[int'(a[7:0]) + k] : ref_mem[int'(a[7:0]) + k];
    return v;
  endfunction

  task automatic mem_wr(input bit env, input logic [ADDRW-1:0] a, input ram_size_t s, input logic [63:0] d);
    for (int k = 0; k < nbytes(s); k++) begin
      if (env) env_mem[int'(a[7:0]) + k] = d[8*k +: 8];
      else     ref_mem[int'(a[7:0]) + k] = d[8*k +: 8];
    end
  endtask

  // Predict what the upcoming clock edge does, from the inputs now being driven.
  task automatic model_edge();
    cyc++;
    if (rst) begin
      act = 0; last = 1; idle_at = cyc + 1; exp_rdata = '0;
    end else begin
      if (act && t_al && !t_we && cyc == tg + 2) exp_rdata = t_rd;
      if (cyc >= idle_at && (req0 || req1)) begin
        t_own = (req0 && req1) ? !last : req1;
        if (t_own) begin t_we = we1; t_sz = size1; t_addr = addr1; t_wd = wdata1; end
        else       begin t_we = we0; t_sz = size0; t_addr = addr0; t_wd = wdata0; end
        t_al = tb_aligned(t_sz, t_addr);
        act = 1; tg = cyc; last = t_own;
        idle_at = cyc + (t_al ? 4 : 2);
        if (!t_al) exp_rdata = '0;
        else if (t_we) mem_wr(0, t_addr, t_sz, t_wd);
        else t_rd = mem_rd(0, t_addr, t_sz);
      end
    end
  endtask

  task automatic compare_all();
    int off;
    bit e_gnt, e_done, e_err, e_busy;
    ram_op_t e_op;
    off    = cyc - tg;
    e_gnt  = act && off == 0;
    e_done = act && off == (t_al ? 2 : 0);
    e_err  = act && !t_al && off == 0;
    e_busy = act && off >= 0 && off < (t_al ? 3 : 1);
    e_op   = RAM_NOP;
    if (act && t_al && off == 0) e_op = t_we ? RAM_STORE : RAM_FETCH;
    check_val("gnt0",  64'(gnt0),  64'(e_gnt && !t_own));
    check_val("gnt1",  64'(gnt1),  64'(e_gnt && t_own));
    check_val("done0", 64'(done0), 64'(e_done && !t_own));
    check_val("done1", 64'(done1), 64'(e_done && t_own));
    check_val("err",   64'(err),   64'(e_err));
    check_val("busy",  64'(busy),  64'(e_busy));
    check_val("ram_op", 64'(ram_op), 64'(e_op));
    check_val("rdata", rdata, exp_rdata);
    if (e_op != RAM_NOP) begin
      check_val("ram_addr", 64'(ram_addr), 64'(t_addr));
      check_val("ram_size", 64'(ram_size), 64'(t_sz));
      if (t_we) check_val("ram_data_in", ram_data_in, t_wd);
    end
  endtask

  // Behavioural RAM: commands act when seen, fetch data shows up one cycle later.
  task automatic env_ram();
    ram_data_out = env_pend_v ? env_pend : {$urandom, $urandom};
    env_pend_v = 0;
    if (ram_op == RAM_STORE) mem_wr(1, ram_addr, ram_size, ram_data_in);
    else if (ram_op == RAM_FETCH) begin
      env_pend = mem_rd(1, ram_addr, ram_size);
      env_pend_v = 1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    env_ram();
  endtask

  task automatic wait_done(input int port, output int lat);
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!(port == 1 ? done1 : done0) && lat < 20);
  endtask

  task automatic rand_payload(output logic w, output ram_size_t s, output logic [ADDRW-1:0] a,
                              output logic [DATAW-1:0] wd);
    int n;
    w  = 1'($urandom_range(1));
    s  = ram_size_t'(2'($urandom_range(3)));
    n  = nbytes(s);
    a  = ADDRW'($urandom_range(255));
    if ($urandom_range(3) != 0) a = ADDRW'((int'(a) / n) * n);
    wd = {$urandom, $urandom};
  endtask

  // Random requester: holds req until done, may scramble payload once granted.
  task automatic agent(input logic d, input logic g, inout logic r, inout bit gr, inout logic w,
                       inout ram_size_t s, inout logic [ADDRW-1:0] a, inout logic [DATAW-1:0] wd);
    if (r) begin
      if (d) begin
        r = 1'b0; gr = 0;
      end else if (g || gr) begin
        gr = 1;
        if ($urandom_range(3) == 0) rand_payload(w, s, a, wd);
      end
    end else if ($urandom_range(2) == 0) begin
      rand_payload(w, s, a, wd);
      r = 1'b1; gr = 0;
    end
  endtask

  initial begin
    int lat, k;
    int order[$];
    int dones[$];
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    size0 = BYTE; size1 = BYTE; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ram_data_out = '0; env_pend = '0; env_pend_v = 0; g0 = 0; g1 = 0;
    act = 0; last = 1; idle_at = 0; tg = 0; exp_rdata = '0; t_rd = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 8'h00; env_mem[i] = 8'h00; end

    // Reset state
    cycle();
    cycle();
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_op", 64'(ram_op), 64'(RAM_NOP));
    rst = 0;
    cycle();

    // Store then fetch a quad through port 0
    req0 = 1; we0 = 1; size0 = QUAD; addr0 = 17'h10; wdata0 = 64'h0123456789ABCDEF;
    wait_done(0, lat);
    check_val("st_lat", 64'(lat), 64'd3);
    req0 = 0;
    cycle();
    req0 = 1; we0 = 0; wdata0 = '0;
    wait_done(0, lat);
    check_val("ld_lat", 64'(lat), 64'd3);
    check_val("ld_data", rdata, 64'h0123456789ABCDEF);
    req0 = 0;
    cycle();

    // Simultaneous held requests alternate, starting from port 0 after reset
    rst = 1;
    cycle();
    rst = 0;
    we0 = 0; size0 = QUAD; addr0 = 17'h10;
    we1 = 0; size1 = QUAD; addr1 = 17'h18;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (done0 || done1) dones.push_back(i);
    end
    check_val("rr_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size(); i++) check_val("rr_order", 64'(order[i]), 64'(i % 2));
    check_val("rr_dones", 64'(dones.size()), 64'd3);
    for (int i = 1; i < dones.size(); i++) check_val("rr_gap", 64'(dones[i] - dones[i-1]), 64'd4);
    req0 = 0; req1 = 0;
    repeat (4) cycle();

    // Misaligned long fetch from port 1
    req1 = 1; we1 = 0; size1 = LONG; addr1 = 17'h6;
    cycle();
    check_val("mis_gnt1", 64'(gnt1), 64'd1);
    check_val("mis_done1", 64'(done1), 64'd1);
    check_val("mis_err", 64'(err), 64'd1);
    check_val("mis_op", 64'(ram_op), 64'(RAM_NOP));
    check_val("mis_rdata", rdata, 64'd0);
    req1 = 0;
    cycle();
    check_val("mis_idle", 64'(busy), 64'd0);

    // Reset during WAIT abandons the fetch; port 1 is then served normally
    req0 = 1; we0 = 0; size0 = QUAD; addr0 = 17'h10;
    cycle();
    cycle();
    rst = 1; req0 = 0;
    cycle();
    check_val("rw_done0", 64'(done0), 64'd0);
    check_val("rw_busy", 64'(busy), 64'd0);
    rst = 0;
    req1 = 1; we1 = 1; size1 = BYTE; addr1 = 17'h21; wdata1 = 64'h5A;
    wait_done(1, lat);
    check_val("rw_lat1", 64'(lat), 64'd3);
    req1 = 0;
    cycle();

    // Port 1 arrives during port 0 ISSUE; port 0 payload changes after its grant
    req0 = 1; we0 = 0; size0 = QUAD; addr0 = 17'h10;
    cycle();
    check_val("ov_gnt0", 64'(gnt0), 64'd1);
    check_val("ov_addr0", 64'(ram_addr), 64'h10);
    req1 = 1; we1 = 0; size1 = WORD; addr1 = 17'h22;
    addr0 = 17'h40; size0 = BYTE; we0 = 1;
    k = 0;
    do begin
      cycle();
      k++;
      if (k == 1) check_val("ov_hold", 64'(ram_addr), 64'h10);
      if (done0) req0 = 0;
    end while (!gnt1 && k < 12);
    check_val("ov_wait", 64'(k), 64'd4);
    check_val("ov_addr1", 64'(ram_addr), 64'h22);
    wait_done(1, lat);
    check_val("ov_lat1", 64'(lat), 64'd2);
    req1 = 0;
    cycle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      cycle();
      if (rst) begin g0 = 0; g1 = 0; end
      agent(done0, gnt0, req0, g0, we0, size0, addr0, wdata0);
      agent(done1, gnt1, req1, g1, we1, size1, addr1, wdata1);
    end
    rst = 0; req0 = 0; req1 = 0;
    repeat (8) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
